// File: rtl/spu_pkg.sv
// Shared constants and types for the SPU execute/writeback datapath.
// Latency tags encode (retire cycles - 1) on both sides of the boundary.
package spu_pkg;

   localparam int SPU_DATA_W = 128;
   localparam int SPU_ADDR_W = 7;
   localparam int SPU_LAT_W  = 3;

   typedef struct packed {
      logic                  valid;
      logic [SPU_ADDR_W-1:0] addr;
      logic [SPU_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/writeback_pipe.sv
// Latency-aligned result pipeline feeding the register-file write port.
// Slot 0 drives the write port; slot L is the insert point for latency L.
module writeback_pipe
   import spu_pkg::*;
#(
   parameter int DATA_W = SPU_DATA_W,
   parameter int ADDR_W = SPU_ADDR_W,
   parameter int LAT_W  = SPU_LAT_W,
   parameter int DEPTH  = 2**LAT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_EX,
   input  logic [DATA_W-1:0] result_EX,
   input  logic [LAT_W-1:0]  latency_EX,
   input  logic [ADDR_W-1:0] rtAddr_EX,
   output logic              stall_EX,
   output logic              regWrite_WB,
   output logic [ADDR_W-1:0] writeAddr_WB,
   output logic [DATA_W-1:0] writeData_WB,
   input  logic [ADDR_W-1:0] fwdAddr,
   output logic              fwdHit,
   output logic [DATA_W-1:0] fwdData,
   output logic              fwdPending,
   output logic [LAT_W:0]    occupancy
);

   function automatic logic [LAT_W:0] popcount(input logic [DEPTH-1:0] v);
      logic [LAT_W:0] n;
      n = '0;
      for (int i = 0; i < DEPTH; i++)
         n = n + {{LAT_W{1'b0}}, v[i]};
      return n;
   endfunction

   wb_entry_t         slot_q [DEPTH];
   wb_entry_t         slot_d [DEPTH];
   wb_entry_t         ins;
   logic [DEPTH-1:0]  next_v;
   logic [DEPTH-1:0]  slot_dv;
   logic [DEPTH-1:0]  pend_v;
   logic              accept;

   assign ins = '{valid: 1'b1, addr: rtAddr_EX, data: result_EX};

   // A slot is taken if it would still hold an entry after this edge's shift.
   assign stall_EX = valid_EX & next_v[latency_EX];
   assign accept   = valid_EX & ~stall_EX;

   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      wb_entry_t shifted;
      if (i < DEPTH - 1) begin : g_mid
         assign shifted = slot_q[i+1];
      end else begin : g_top
         assign shifted = '0;
      end
      assign next_v[i]  = shifted.valid;
      assign slot_d[i]  = (accept && latency_EX == LAT_W'(i)) ? ins : shifted;
      assign slot_dv[i] = slot_d[i].valid;
      if (i == 0) begin : g_head
         assign pend_v[i] = 1'b0;
      end else begin : g_tail
         assign pend_v[i] = slot_q[i].valid && (slot_q[i].addr == fwdAddr);
      end
   end

   // Advance the slot array and track how many slots will be occupied.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            slot_q[i] <= '0;
         occupancy <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            slot_q[i] <= slot_d[i];
         occupancy <= popcount(slot_dv);
      end
   end

   assign regWrite_WB  = slot_q[0].valid;
   assign writeAddr_WB = slot_q[0].addr;
   assign writeData_WB = slot_q[0].data;

   assign fwdHit     = slot_q[0].valid && (slot_q[0].addr == fwdAddr);
   assign fwdData    = fwdHit ? slot_q[0].data : '0;
   assign fwdPending = |pend_v;

endmodule

// File: tb/tb_writeback_pipe.sv
// Directed bench for writeback_pipe with a due-cycle model of in-flight results.
// Each accepted result is tracked by the edge index at which it must retire.
module tb_writeback_pipe;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          valid_EX = 1'b0;
   logic [127:0]  result_EX = '0;
   logic [2:0]    latency_EX = '0;
   logic [6:0]    rtAddr_EX = '0;
   logic          stall_EX;
   logic          regWrite_WB;
   logic [6:0]    writeAddr_WB;
   logic [127:0]  writeData_WB;
   logic [6:0]    fwdAddr = '0;
   logic          fwdHit;
   logic [127:0]  fwdData;
   logic          fwdPending;
   logic [3:0]    occupancy;

   writeback_pipe dut (
      .clk(clk), .reset(reset), .valid_EX(valid_EX),
      .result_EX(result_EX), .latency_EX(latency_EX),
      .rtAddr_EX(rtAddr_EX), .stall_EX(stall_EX),
      .regWrite_WB(regWrite_WB), .writeAddr_WB(writeAddr_WB),
      .writeData_WB(writeData_WB), .fwdAddr(fwdAddr),
      .fwdHit(fwdHit), .fwdData(fwdData),
      .fwdPending(fwdPending), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           due;
      logic [6:0]   addr;
      logic [127:0] data;
   } ent_t;

   ent_t q[$];
   ent_t nq[$];
   int   cur = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   armed = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   function automatic bit m_stall();
      bit s = 0;
      if (valid_EX)
         foreach (q[i])
            if (q[i].due == cur + 1 + int'(latency_EX)) s = 1;
      return s;
   endfunction

   function automatic int m_occ();
      int n = 0;
      foreach (q[i]) if (q[i].due >= cur) n++;
      return n;
   endfunction

   function automatic bit m_pend();
      bit p = 0;
      foreach (q[i])
         if (q[i].due > cur && q[i].addr == fwdAddr) p = 1;
      return p;
   endfunction

   // Model: retire bookkeeping and acceptance at each rising edge.
   always @(posedge clk) begin
      if (reset) begin
         q.delete();
      end else begin
         bit st;
         st = m_stall();
         nq.delete();
         foreach (q[i]) if (q[i].due >= cur + 1) nq.push_back(q[i]);
         q = nq;
         if (valid_EX && !st)
            q.push_back('{cur + 1 + int'(latency_EX), rtAddr_EX, result_EX});
      end
      cur = cur + 1;
   end

   // Compare every output against the model once per cycle.
   always @(negedge clk) begin
      if (armed) begin
         bit           wr;
         bit           hit;
         logic [6:0]   wa;
         logic [127:0] wd;
         wr = 0; hit = 0; wa = '0; wd = '0;
         foreach (q[i])
            if (q[i].due == cur) begin
               wr = 1; wa = q[i].addr; wd = q[i].data;
            end
         hit = wr && (wa == fwdAddr);
         chk("regWrite", 128'(regWrite_WB), 128'(wr));
         if (wr) begin
            chk("writeAddr", 128'(writeAddr_WB), 128'(wa));
            chk("writeData", writeData_WB, wd);
         end
         chk("stall", 128'(stall_EX), 128'(m_stall()));
         chk("fwdHit", 128'(fwdHit), 128'(hit));
         chk("fwdData", fwdData, hit ? wd : 128'd0);
         chk("fwdPending", 128'(fwdPending), 128'(m_pend()));
         chk("occupancy", 128'(occupancy), 128'(m_occ()));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic put(input logic [2:0] l, input logic [6:0] a,
                      input logic [127:0] d);
      valid_EX = 1'b1; latency_EX = l; rtAddr_EX = a; result_EX = d;
   endtask

   initial begin
      int pulses;

      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      armed = 1;
      at_neg();
      chk("rst_regWrite", 128'(regWrite_WB), 128'd0);
      chk("rst_occ", 128'(occupancy), 128'd0);
      chk("rst_stall", 128'(stall_EX), 128'd0);
      chk("rst_fwd", 128'({fwdHit, fwdPending}), 128'd0);

      // single result, L=2
      cyc();
      put(3'd2, 7'd5, {16{8'hAA}});
      cyc();
      valid_EX = 1'b0;
      at_neg();
      chk("single_occ0", 128'(occupancy), 128'd1);
      chk("single_rw0", 128'(regWrite_WB), 128'd0);
      cyc();
      at_neg();
      chk("single_occ1", 128'(occupancy), 128'd1);
      chk("single_rw1", 128'(regWrite_WB), 128'd0);
      cyc();
      at_neg();
      chk("single_occ2", 128'(occupancy), 128'd1);
      chk("single_rw2", 128'(regWrite_WB), 128'd1);
      chk("single_addr", 128'(writeAddr_WB), 128'd5);
      chk("single_data", writeData_WB, {16{8'hAA}});
      cyc();
      at_neg();
      chk("single_occ3", 128'(occupancy), 128'd0);
      chk("single_rw3", 128'(regWrite_WB), 128'd0);

      // mixed latencies: A L=4 then B L=0
      cyc();
      put(3'd4, 7'd1, 128'h11);
      cyc();
      put(3'd0, 7'd2, 128'h22);
      at_neg();
      chk("mix_stall", 128'(stall_EX), 128'd0);
      cyc();
      valid_EX = 1'b0;
      at_neg();
      chk("mix_b_addr", 128'({regWrite_WB, writeAddr_WB}), 128'({1'b1, 7'd2}));
      cyc();
      cyc();
      cyc();
      at_neg();
      chk("mix_a_addr", 128'({regWrite_WB, writeAddr_WB}), 128'({1'b1, 7'd1}));

      // collision: A L=3 then B L=2 must wait one cycle
      cyc();
      put(3'd3, 7'd3, 128'h33);
      at_neg();
      chk("col_stall_a", 128'(stall_EX), 128'd0);
      cyc();
      put(3'd2, 7'd4, 128'h44);
      at_neg();
      chk("col_stall_b1", 128'(stall_EX), 128'd1);
      cyc();
      at_neg();
      chk("col_stall_b2", 128'(stall_EX), 128'd0);
      cyc();
      valid_EX = 1'b0;
      at_neg();
      chk("col_rw_k2", 128'(regWrite_WB), 128'd0);
      cyc();
      at_neg();
      chk("col_a_wr", 128'({regWrite_WB, writeAddr_WB}), 128'({1'b1, 7'd3}));
      cyc();
      at_neg();
      chk("col_b_wr", 128'({regWrite_WB, writeAddr_WB}), 128'({1'b1, 7'd4}));
      chk("col_b_data", writeData_WB, 128'h44);

      // forwarding on addr 9
      cyc();
      fwdAddr = 7'd9;
      put(3'd2, 7'd9, 128'h9999_0000_9999);
      cyc();
      valid_EX = 1'b0;
      at_neg();
      chk("fwd_pend", 128'({fwdPending, fwdHit}), 128'({1'b1, 1'b0}));
      cyc();
      cyc();
      at_neg();
      chk("fwd_hit", 128'({fwdPending, fwdHit}), 128'({1'b0, 1'b1}));
      chk("fwd_data", fwdData, 128'h9999_0000_9999);
      fwdAddr = 7'd10;
      #1;
      chk("fwd_miss", 128'({fwdPending, fwdHit}), 128'd0);
      chk("fwd_miss_data", fwdData, 128'd0);

      // reset mid-flight
      cyc();
      for (int i = 0; i < 4; i++) begin
         put(3'd7, 7'(40 + i), 128'(i + 100));
         cyc();
      end
      reset = 1'b1;
      put(3'd0, 7'h7f, 128'h7f);
      cyc();
      reset = 1'b0;
      put(3'd3, 7'h30, 128'h30);
      at_neg();
      chk("mrst_occ", 128'(occupancy), 128'd0);
      chk("mrst_stall", 128'(stall_EX), 128'd0);
      chk("mrst_rw", 128'(regWrite_WB), 128'd0);
      valid_EX = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         at_neg();
         if (regWrite_WB) pulses++;
      end
      chk("mrst_pulses", 128'(pulses), 128'd0);

      // back-to-back L=7
      cyc();
      for (int i = 0; i < 8; i++) begin
         put(3'd7, 7'(20 + i), 128'(i + 1));
         at_neg();
         chk("b2b_stall", 128'(stall_EX), 128'd0);
         cyc();
      end
      valid_EX = 1'b0;
      at_neg();
      chk("b2b_occ", 128'(occupancy), 128'd8);
      chk("b2b_w0", 128'({regWrite_WB, writeAddr_WB}), 128'({1'b1, 7'd20}));
      for (int i = 1; i < 8; i++) begin
         cyc();
         at_neg();
         chk("b2b_w", 128'({regWrite_WB, writeAddr_WB}),
             128'({1'b1, 7'(20 + i)}));
         chk("b2b_d", writeData_WB, 128'(i + 1));
      end
      cyc();
      at_neg();
      chk("b2b_done", 128'(regWrite_WB), 128'd0);

      cyc();
      armed = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
